abz_quad_counter: RTL and testbench

//  Parametrised quadrature (A/B/Z) position counter; successor of the fixed-x4, fixed-wrap detector.

---
 rtl/abz_pkg.sv | 23 ++
 rtl/abz_quad_counter_if.sv | 42 ++++
 rtl/abz_glitch_filter.sv | 50 +++++
 rtl/abz_quad_counter.sv | 166 ++++++++++++++++
 tb/tb_abz_quad_counter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/abz_pkg.sv
// abz_pkg: shared encodings for the A/B/Z quadrature position counter.
//   MODE_*   : count resolution select (x1 / x2 / x4; 2'b11 also decodes as x4)
//   z_mode_e : index pulse handling (off / load / capture / one-shot load)
//   state_e  : top-level sequencing (startup guard, run)
package abz_pkg;

    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X4 = 2'b10;

    typedef enum logic [1:0] {
        ZM_OFF  = 2'b00,
        ZM_LOAD = 2'b01,
        ZM_CAPT = 2'b10,
        ZM_ONCE = 2'b11
    } z_mode_e;

    typedef enum logic {
        ST_STARTUP = 1'b0,
        ST_RUN     = 1'b1
    } state_e;

endpackage

// File: rtl/abz_quad_counter_if.sv
// abz_quad_counter_if: control/status bus between the quadrature counter and
// the position register bank.
//   slave  : the counter (consumes configuration, produces position/status)
//   master : the register bank side
interface abz_quad_counter_if #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
);
    logic [1:0]       MODE;
    logic [1:0]       Z_MODE;
    logic             Z_ARM;
    logic             EN_INIT_IN;
    logic [CNT_W-1:0] INIT_COUNT;
    logic [CNT_W-1:0] POS_OFFSET;
    logic [CNT_W-1:0] CNT_MAX;
    logic             EN_OUTPUT_IN;
    logic             ERR_CLR;

    logic [CNT_W-1:0] CNT_OUT;
    logic [CNT_W-1:0] CNT_OUT_LATCH;
    logic [CNT_W-1:0] Z_CAPT;
    logic             Z_SEEN;
    logic             DIR_OUT;
    logic             READY;
    logic             ERR_STICKY;
    logic [ERR_W-1:0] ERR_CNT;

    modport slave (
        input  MODE, Z_MODE, Z_ARM, EN_INIT_IN, INIT_COUNT, POS_OFFSET,
               CNT_MAX, EN_OUTPUT_IN, ERR_CLR,
        output CNT_OUT, CNT_OUT_LATCH, Z_CAPT, Z_SEEN, DIR_OUT, READY,
               ERR_STICKY, ERR_CNT
    );

    modport master (
        output MODE, Z_MODE, Z_ARM, EN_INIT_IN, INIT_COUNT, POS_OFFSET,
               CNT_MAX, EN_OUTPUT_IN, ERR_CLR,
        input  CNT_OUT, CNT_OUT_LATCH, Z_CAPT, Z_SEEN, DIR_OUT, READY,
               ERR_STICKY, ERR_CNT
    );

endinterface

// File: rtl/abz_glitch_filter.sv
// abz_glitch_filter: synchroniser + run-length glitch filter for one encoder pin.
//   CLK, ARSTN : clock, synchronous active-low reset
//   pin        : asynchronous pin input
//   filt       : filtered level
//   rise, fall : 1-cycle flags, valid in the same cycle filt shows its new level
module abz_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic CLK,
    input  logic ARSTN,
    input  logic pin,
    output logic filt,
    output logic rise,
    output logic fall
);
    localparam int RUN_W = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [RUN_W-1:0]       run_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (!ARSTN) begin
            sync_q <= '0;
            run_q  <= '0;
            filt   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (synced == filt) begin
                run_q <= '0;
            end else if (run_q == RUN_W'(FILT_LEN - 1)) begin
                // FILT_LEN-th disagreeing sample: accept the new level
                run_q <= '0;
                filt  <= synced;
                rise  <= synced;
                fall  <= ~synced;
            end else begin
                run_q <= run_q + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/abz_quad_counter.sv
// abz_quad_counter: quadrature A/B/Z position counter.
//   CLK, ARSTN       : clock, synchronous active-low reset
//   A_IN, B_IN, Z_IN : asynchronous encoder pins
//   bus (slave)      : configuration in (MODE, Z_MODE, Z_ARM, EN_INIT_IN,
//                      INIT_COUNT, POS_OFFSET, CNT_MAX, EN_OUTPUT_IN, ERR_CLR),
//                      position/status out (CNT_OUT, CNT_OUT_LATCH, Z_CAPT,
//                      Z_SEEN, DIR_OUT, READY, ERR_STICKY, ERR_CNT)
// Each pin passes a synchroniser and glitch filter; step decode, wrap, Z handling,
// startup guard and error counting live here. Per-cycle priority is
// INIT edge > Z load > step; a losing step is dropped.
module abz_quad_counter
    import abz_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int ERR_W       = 8
) (
    input  logic              CLK,
    input  logic              ARSTN,
    input  logic              A_IN,
    input  logic              B_IN,
    input  logic              Z_IN,
    abz_quad_counter_if.slave bus
);
    localparam int SU_LEN = SYNC_STAGES + FILT_LEN + 1;
    localparam int SU_W   = $clog2(SU_LEN + 1);

    logic a_f, a_r, a_fl;
    logic b_f, b_r, b_fl;
    logic z_f, z_r, z_fl;

    abz_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .CLK(CLK), .ARSTN(ARSTN), .pin(A_IN), .filt(a_f), .rise(a_r), .fall(a_fl));
    abz_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .CLK(CLK), .ARSTN(ARSTN), .pin(B_IN), .filt(b_f), .rise(b_r), .fall(b_fl));
    abz_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_z (
        .CLK(CLK), .ARSTN(ARSTN), .pin(Z_IN), .filt(z_f), .rise(z_r), .fall(z_fl));

    // ---------------- startup guard FSM ----------------
    state_e           state_q, state_d;
    logic [SU_W-1:0]  su_cnt_q, su_cnt_d;
    logic             run;

    always_ff @(posedge CLK) begin
        if (!ARSTN) begin
            state_q  <= ST_STARTUP;
            su_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            su_cnt_q <= su_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        su_cnt_d = su_cnt_q;
        case (state_q)
            ST_STARTUP: begin
                if (su_cnt_q == SU_W'(SU_LEN - 1)) state_d = ST_RUN;
                else                               su_cnt_d = su_cnt_q + SU_W'(1);
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_STARTUP;
        endcase
    end

    assign run = (state_q == ST_RUN);

    // ---------------- step decode ----------------
    // The previous filtered {A,B} is recovered from the edge flags: at most one
    // toggle per pin per cycle, so prev = cur ^ changed.
    logic a_chg, b_chg, illegal, legal, step_up, cnt_en, do_step;
    z_mode_e zm;

    assign a_chg   = a_r | a_fl;
    assign b_chg   = b_r | b_fl;
    assign illegal = run & a_chg & b_chg;
    assign legal   = run & (a_chg ^ b_chg);
    // On the up sequence 00->10->11->01, an A edge lands on A!=B and a B edge on A==B.
    assign step_up = a_chg ? (a_f ^ b_f) : ~(a_f ^ b_f);

    always_comb begin
        case (bus.MODE)
            MODE_X1: cnt_en = a_chg & ~b_f;
            MODE_X2: cnt_en = a_chg;
            default: cnt_en = 1'b1;
        endcase
    end

    assign do_step = legal & cnt_en;

    // ---------------- Z / INIT qualification ----------------
    logic [CNT_W-1:0] cnt_q, cnt_d, z_capt_q, latch_q;
    logic             dir_q, arm_q, en_init_q, z_seen_q;
    logic             qz, z_load, z_load_eff, init_edge;

    assign zm         = z_mode_e'(bus.Z_MODE);
    assign qz         = run & (dir_q ? z_r : z_fl) & (zm != ZM_OFF);
    assign z_load     = qz & ((zm == ZM_LOAD) | ((zm == ZM_ONCE) & (arm_q | bus.Z_ARM)));
    assign init_edge  = run & bus.EN_INIT_IN & ~en_init_q;
    assign z_load_eff = z_load & ~init_edge;

    always_comb begin
        cnt_d = cnt_q;
        if (init_edge)
            cnt_d = bus.INIT_COUNT;
        else if (z_load)
            cnt_d = bus.POS_OFFSET;
        else if (do_step) begin
            if (step_up) cnt_d = (cnt_q >= bus.CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
            else         cnt_d = (cnt_q == '0) ? bus.CNT_MAX : cnt_q - CNT_W'(1);
        end
    end

    // ---------------- state registers ----------------
    logic             err_sticky_q;
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge CLK) begin
        if (!ARSTN) begin
            cnt_q        <= '0;
            z_capt_q     <= '0;
            latch_q      <= '0;
            dir_q        <= 1'b0;
            arm_q        <= 1'b0;
            en_init_q    <= 1'b0;
            z_seen_q     <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            // edge detector tracks during startup so a held-high level is not an edge later
            en_init_q <= bus.EN_INIT_IN;
            cnt_q     <= cnt_d;
            z_seen_q  <= qz;
            if (qz)               z_capt_q <= cnt_q;
            if (legal)            dir_q    <= step_up;
            if (bus.EN_OUTPUT_IN) latch_q  <= cnt_q;

            if (run) begin
                if (z_load_eff && zm == ZM_ONCE) arm_q <= 1'b0;
                else if (bus.Z_ARM)              arm_q <= 1'b1;
            end

            // a fresh illegal transition beats a same-cycle clear
            if (illegal) begin
                err_sticky_q <= 1'b1;
                if (bus.ERR_CLR)         err_cnt_q <= ERR_W'(1);
                else if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
            end else if (bus.ERR_CLR) begin
                err_sticky_q <= 1'b0;
                err_cnt_q    <= '0;
            end
        end
    end

    assign bus.CNT_OUT       = cnt_q;
    assign bus.CNT_OUT_LATCH = latch_q;
    assign bus.Z_CAPT        = z_capt_q;
    assign bus.Z_SEEN        = z_seen_q;
    assign bus.DIR_OUT       = dir_q;
    assign bus.READY         = run;
    assign bus.ERR_STICKY    = err_sticky_q;
    assign bus.ERR_CNT       = err_cnt_q;

endmodule

// File: tb/tb_abz_quad_counter.sv
// tb_abz_quad_counter: self-checking bench for abz_quad_counter.
// Directed tables for wrap and stepping, hand-written sequences for filter,
// Z and error corner cases, then a randomized walk against a position model
// that works on quadrature phase indices.
module tb_abz_quad_counter;
    localparam int CNT_W   = 16;
    localparam int ERR_W   = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic CLK = 1'b0;
    logic ARSTN, A_IN, B_IN, Z_IN;

    abz_quad_counter_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

    abz_quad_counter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .FILT_LEN(4), .ERR_W(ERR_W)) dut (
        .CLK(CLK), .ARSTN(ARSTN), .A_IN(A_IN), .B_IN(B_IN), .Z_IN(Z_IN), .bus(bus));

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int   m_cnt, m_max, m_mode, m_err;
    logic m_a, m_b, m_dir, m_sticky;

    typedef struct {
        logic a;
        logic b;
        int   cnt;
        logic dir;
    } vec_t;
    vec_t tbl[15];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // position on the up cycle 00 -> 10 -> 11 -> 01
    function automatic int gidx(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_move(input logic a, input logic b);
        int   d;
        logic up, counts;
        d = (gidx(a, b) - gidx(m_a, m_b) + 4) % 4;
        if (d == 2) begin
            m_sticky = 1'b1;
            if (m_err < ERR_MAX) m_err++;
        end else if (d != 0) begin
            up    = (d == 1);
            m_dir = up;
            if (m_mode == 0)      counts = (a != m_a) && !b;
            else if (m_mode == 1) counts = (a != m_a);
            else                  counts = 1'b1;
            if (counts) begin
                if (up) m_cnt = (m_cnt >= m_max) ? 0 : m_cnt + 1;
                else    m_cnt = (m_cnt == 0) ? m_max : m_cnt - 1;
            end
        end
        m_a = a;
        m_b = b;
    endtask

    // drive a settled pin level and let it propagate fully (latency 7 clk)
    task automatic step_ab(input logic a, input logic b);
        A_IN = a;
        B_IN = b;
        repeat (8) tick();
        model_move(a, b);
    endtask

    task automatic do_init(input int val);
        bus.INIT_COUNT = CNT_W'(val);
        bus.EN_INIT_IN = 1'b1;
        tick();
        bus.EN_INIT_IN = 1'b0;
        tick();
        m_cnt = val;
    endtask

    task automatic set_max(input int val);
        m_max = val;
        bus.CNT_MAX = CNT_W'(val);
    endtask

    task automatic set_mode(input int val);
        logic [1:0] mv;
        m_mode  = val;
        mv      = 2'(val);
        bus.MODE = mv;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " cnt"}, int'(bus.CNT_OUT), m_cnt);
        chk({tag, " dir"}, int'(bus.DIR_OUT), int'(m_dir));
        chk({tag, " err_cnt"}, int'(bus.ERR_CNT), m_err);
        chk({tag, " sticky"}, int'(bus.ERR_STICKY), int'(m_sticky));
    endtask

    task automatic z_pulse(output int seen);
        seen = 0;
        Z_IN = 1'b1;
        repeat (8) begin tick(); if (bus.Z_SEEN) seen++; end
        Z_IN = 1'b0;
        repeat (8) begin tick(); if (bus.Z_SEEN) seen++; end
    endtask

    initial begin
        int seen, oi, ni, r;
        logic [1:0] ab;

        // x4 table from AB=11: 12 up steps with CNT_MAX=9, then 3 down from 0
        tbl[0]  = '{1'b0, 1'b1, 1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 2, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 3, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 4, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 5, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 6, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 7, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 8, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 9, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 2, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 9, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 7, 1'b0};

        ARSTN = 1'b0; A_IN = 1'b1; B_IN = 1'b1; Z_IN = 1'b0;
        bus.MODE = 2'b10; bus.Z_MODE = 2'b00; bus.Z_ARM = 1'b0;
        bus.EN_INIT_IN = 1'b0; bus.INIT_COUNT = '0; bus.POS_OFFSET = '0;
        bus.CNT_MAX = 16'd9; bus.EN_OUTPUT_IN = 1'b0; bus.ERR_CLR = 1'b0;
        m_cnt = 0; m_max = 9; m_mode = 2; m_err = 0;
        m_a = 1'b1; m_b = 1'b1; m_dir = 1'b0; m_sticky = 1'b0;

        // ---- 1: reset and startup guard ----
        repeat (3) tick();
        chk("rst cnt", int'(bus.CNT_OUT), 0);
        chk("rst ready", int'(bus.READY), 0);
        chk("rst dir", int'(bus.DIR_OUT), 0);
        chk("rst err", int'(bus.ERR_CNT), 0);
        chk("rst zcapt", int'(bus.Z_CAPT), 0);
        ARSTN = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("startup ready c%0d", k), int'(bus.READY), (k >= 7) ? 1 : 0);
        end
        chk_model("startup");

        // ---- 2: x4 wrap table ----
        for (int i = 0; i < 15; i++) begin
            if (i == 12) begin
                do_init(0);
                chk("init0 cnt", int'(bus.CNT_OUT), 0);
            end
            step_ab(tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d cnt", i), int'(bus.CNT_OUT), tbl[i].cnt);
            chk($sformatf("tbl%0d dir", i), int'(bus.DIR_OUT), int'(tbl[i].dir));
        end

        // ---- 3: x1 and x2 resolution ----
        set_max(100);
        for (int md = 0; md < 2; md++) begin
            set_mode(md);
            step_ab(1'b0, 1'b0);
            do_init(0);
            for (int c = 0; c < 8; c++) begin
                step_ab(1'b1, 1'b0); step_ab(1'b1, 1'b1);
                step_ab(1'b0, 1'b1); step_ab(1'b0, 1'b0);
            end
            chk($sformatf("x%0d fwd cnt", md + 1), int'(bus.CNT_OUT), (md == 0) ? 8 : 16);
            for (int c = 0; c < 8; c++) begin
                step_ab(1'b0, 1'b1); step_ab(1'b1, 1'b1);
                step_ab(1'b1, 1'b0); step_ab(1'b0, 1'b0);
            end
            chk($sformatf("x%0d rev cnt", md + 1), int'(bus.CNT_OUT), 0);
            chk_model($sformatf("x%0d", md + 1));
        end

        // ---- 4: glitch filter ----
        set_mode(2);
        do_init(5);
        A_IN = 1'b1; repeat (3) tick(); A_IN = 1'b0; repeat (10) tick();
        chk("glitch3 cnt", int'(bus.CNT_OUT), 5);
        A_IN = 1'b1; repeat (5) tick(); A_IN = 1'b0; repeat (2) tick();
        chk("pulse5 up cnt", int'(bus.CNT_OUT), 6);
        repeat (8) tick();
        chk("pulse5 back cnt", int'(bus.CNT_OUT), 5);
        m_dir = 1'b0;
        chk_model("pulse5");

        // ---- 5: Z handling ----
        set_max(16'hFFFF);
        bus.Z_MODE = 2'b11;
        bus.POS_OFFSET = 16'h0100;
        step_ab(1'b1, 1'b0);
        z_pulse(seen);
        chk("z unarmed seen", seen, 1);
        chk("z unarmed cnt", int'(bus.CNT_OUT), 6);
        chk("z unarmed capt", int'(bus.Z_CAPT), 6);
        step_ab(1'b1, 1'b1);
        chk("z continue cnt", int'(bus.CNT_OUT), 7);
        bus.Z_ARM = 1'b1; tick(); bus.Z_ARM = 1'b0;
        z_pulse(seen);
        chk("z armed cnt", int'(bus.CNT_OUT), 16'h0100);
        chk("z armed capt", int'(bus.Z_CAPT), 7);
        m_cnt = 16'h0100;
        z_pulse(seen);
        chk("z disarmed cnt", int'(bus.CNT_OUT), 16'h0100);
        chk("z disarmed capt", int'(bus.Z_CAPT), 16'h0100);
        step_ab(1'b0, 1'b1);
        // Z_ARM in the very cycle the qualified Z is acted on
        Z_IN = 1'b1; repeat (6) tick();
        bus.Z_ARM = 1'b1; tick(); bus.Z_ARM = 1'b0;
        chk("z arm+z cnt", int'(bus.CNT_OUT), 16'h0100);
        Z_IN = 1'b0; repeat (8) tick();
        m_cnt = 16'h0100;
        step_ab(1'b0, 1'b0);
        z_pulse(seen);
        chk("z arm cleared cnt", int'(bus.CNT_OUT), 16'h0101);
        // INIT edge against a Z load in the same cycle
        bus.Z_MODE = 2'b01;
        bus.INIT_COUNT = 16'h0055;
        Z_IN = 1'b1; repeat (6) tick();
        bus.EN_INIT_IN = 1'b1; tick();
        chk("init vs z cnt", int'(bus.CNT_OUT), 16'h0055);
        chk("init vs z seen", int'(bus.Z_SEEN), 1);
        chk("init vs z capt", int'(bus.Z_CAPT), 16'h0101);
        bus.EN_INIT_IN = 1'b0; Z_IN = 1'b0; repeat (8) tick();
        m_cnt = 16'h0055;
        // output latch
        bus.EN_OUTPUT_IN = 1'b1; tick(); bus.EN_OUTPUT_IN = 1'b0;
        chk("latch load", int'(bus.CNT_OUT_LATCH), 16'h0055);
        step_ab(1'b1, 1'b0);
        chk("latch hold", int'(bus.CNT_OUT_LATCH), 16'h0055);
        chk_model("z");

        // ---- 6: illegal transitions ----
        bus.Z_MODE = 2'b00;
        step_ab(1'b0, 1'b1);
        chk("illegal sticky", int'(bus.ERR_STICKY), 1);
        chk("illegal err", int'(bus.ERR_CNT), 1);
        chk("illegal cnt", int'(bus.CNT_OUT), 16'h0056);
        chk("illegal dir", int'(bus.DIR_OUT), 1);
        for (int i = 0; i < 300; i++) step_ab(!m_a, !m_b);
        chk("err saturate", int'(bus.ERR_CNT), ERR_MAX);
        bus.ERR_CLR = 1'b1; tick(); bus.ERR_CLR = 1'b0; tick();
        chk("err clr cnt", int'(bus.ERR_CNT), 0);
        chk("err clr sticky", int'(bus.ERR_STICKY), 0);
        m_err = 0; m_sticky = 1'b0;
        step_ab(!m_a, !m_b);
        step_ab(!m_a, !m_b);
        chk("err two", int'(bus.ERR_CNT), 2);
        A_IN = !m_a; B_IN = !m_b; repeat (6) tick();
        bus.ERR_CLR = 1'b1; tick(); bus.ERR_CLR = 1'b0; tick();
        chk("err clr+illegal cnt", int'(bus.ERR_CNT), 1);
        chk("err clr+illegal sticky", int'(bus.ERR_STICKY), 1);
        m_a = A_IN; m_b = B_IN; m_err = 1; m_sticky = 1'b1;

        // CNT_MAX=0 holds the count at 0 in both directions
        set_max(0);
        oi = gidx(m_a, m_b);
        ab = (oi == 0) ? 2'b10 : (oi == 1) ? 2'b11 : (oi == 2) ? 2'b01 : 2'b00;
        step_ab(ab[1], ab[0]);
        chk("max0 up cnt", int'(bus.CNT_OUT), 0);
        step_ab(!ab[1] ^ ab[0] ? ab[1] : ab[1], ab[0]);
        A_IN = m_a; B_IN = m_b;
        oi = gidx(m_a, m_b);
        ab = (oi == 0) ? 2'b01 : (oi == 1) ? 2'b00 : (oi == 2) ? 2'b10 : 2'b11;
        step_ab(ab[1], ab[0]);
        chk("max0 down cnt", int'(bus.CNT_OUT), 0);
        chk_model("max0");

        // ---- randomized walk ----
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                step_ab(!m_a, !m_b);
            end else if (r == 1) begin
                set_mode($urandom_range(0, 3));
            end else if (r == 2) begin
                set_max($urandom_range(0, 20));
            end else if (r == 3) begin
                do_init($urandom_range(0, m_max + 3));
            end else begin
                oi = gidx(m_a, m_b);
                ni = (oi + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
                ab = (ni == 0) ? 2'b00 : (ni == 1) ? 2'b10 : (ni == 2) ? 2'b11 : 2'b01;
                step_ab(ab[1], ab[0]);
            end
            chk_model($sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
